mem_stream_reader: RTL
======================

// Module: mem_stream_reader
// PURPOSE
//  Read-side sequencer for the dual-port BRAM: walks port B (read-only, 1-cycle
//  registered read) from a base address with a programmable stride and streams
//  the words out on a valid/ready interface toward the systolic array feeders.
//  Absorbs the BRAM read latency under backpressure with a 2-entry output FIFO.
// PARAMETERS
//  WIDTH      8                   data word width (matches memory WIDTH)
//  DEPTH      1024                memory depth in words
//  ADDR_WIDTH $clog2(DEPTH)       memory address width
//  LEN_WIDTH  ADDR_WIDTH+1        transfer length counter width
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous active-low reset
//  start      in   1           begin transfer; sampled only in IDLE
//  base_addr  in   ADDR_WIDTH  first word address (latched on start)
//  length     in   LEN_WIDTH   words to read (latched on start), 0 allowed
//  stride     in   ADDR_WIDTH  address increment per word (latched on start)
//  mem_addr   out  ADDR_WIDTH  to memory port B address
//  mem_rdata  in   WIDTH       from memory port B data (valid 1 cycle after addr)
//  m_valid    out  1           output word valid
//  m_ready    in   1           downstream accepts word
//  m_data     out  WIDTH       output word
//  m_last     out  1           marks final word of transfer (qualified by m_valid)
//  busy       out  1           high from accepted start until done
//  done       out  1           1-cycle pulse when transfer fully drained
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM->IDLE; m_valid, m_last, busy, done=0; mem_addr=0;
//   FIFO emptied, in-flight flag cleared, counters 0. Mid-transfer reset aborts
//   it with no further beats; pending mem_rdata is discarded.
//  FSM: IDLE -(start & length!=0)-> RUN -(all reads issued)-> DRAIN
//   -(last beat handshaken)-> IDLE with done=1 for one cycle.
//   IDLE -(start & length==0)-> IDLE, busy stays 0, done=1 next cycle, no beats.
//  start while busy: ignored. Latched base/length/stride immune to input changes.
//  Read issue (RUN): rd_en = issued<length & (occ + inflight - pop) < 2, where
//   occ = FIFO count, inflight = read issued last cycle, pop = m_valid&m_ready.
//   mem_addr = current address register; on rd_en, addr <= addr+stride
//   modulo 2^ADDR_WIDTH (wrap-around, no error), issued <= issued+1.
//  Return: word read at cycle N appears on mem_rdata in N+1, pushed into FIFO at
//   end of N+1; tagged last if it was read index length-1. FIFO never overflows
//   (guaranteed by rd_en rule); push and pop in same cycle allowed.
//  Output: m_valid = FIFO non-empty; m_data/m_last from FIFO head; head holds
//   stable while m_valid & !m_ready (AXI-style, valid never drops without ready).
//  Latency: start sampled at edge E0 -> mem_addr=base in cycle 1 -> m_valid in
//   cycle 3 (first word). Throughput 1 word/cycle with m_ready held high.
//  done asserted the cycle after the m_last handshake; busy deasserts same cycle.
//   New start accepted in that done cycle (FSM already IDLE).
//  mem_addr holds its last value when not reading; port B reads are side-effect
//   free so redundant reads are harmless but data is only pushed when rd_en.
// TESTING
//  1 mem[i]=i; base=0,len=8,stride=1, m_ready=1 -> data 0..7 on 8 consecutive
//    cycles from cycle 3, m_last with 7, done one cycle later.
//  2 base=1020,len=6,stride=2, DEPTH=1024 -> addrs 1020,1022,0,2,4,6 (wrap).
//  3 len=16, m_ready toggled random/held low 10 cycles -> no loss/duplication,
//    m_data stable while stalled, FIFO never >2, order preserved.
//  4 len=0 start -> no m_valid ever, done pulse next cycle, busy stays 0.
//  5 start pulsed again mid-transfer with different base -> ignored; original
//    stream completes unchanged.
//  6 rst_n low after 3 beats of len=10 -> outputs 0 immediately (async); new
//    start base=0,len=2 after release -> exactly 2 beats, correct data.

Source files
------------

// File: rtl/mem_stream_reader.sv
// Streams words from a 1-cycle-latency read port, starting at a base address and
// stepping by a fixed stride, through a 2-entry output buffer on a valid/ready port.
module mem_stream_reader #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [ADDR_WIDTH-1:0] stride,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0]      mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  logic [LEN_WIDTH-1:0]  len_r;
  logic [LEN_WIDTH-1:0]  issued_r;
  logic [ADDR_WIDTH-1:0] stride_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  inflight_r;
  logic                  inflight_last_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  head_v_r;
  logic [WIDTH-1:0]      head_d_r;
  logic                  head_l_r;
  logic                  tail_v_r;
  logic [WIDTH-1:0]      tail_d_r;
  logic                  tail_l_r;

  logic                  pop_s;
  logic                  rd_en_s;
  logic                  last_issue_s;
  logic [2:0]            occ_s;

  assign mem_addr = addr_r;
  assign m_valid  = head_v_r;
  assign m_data   = head_d_r;
  assign m_last   = head_l_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Read-issue decision: count buffered words plus the one in flight, minus the one leaving.
  always_comb begin
    pop_s        = head_v_r & m_ready;
    occ_s        = 3'(head_v_r) + 3'(tail_v_r) + 3'(inflight_r) - 3'(pop_s);
    last_issue_s = (issued_r == (len_r - LEN_WIDTH'(1)));
    if ((state_r == RUN) && (issued_r < len_r) && (occ_s < 3'd2)) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Sequencer FSM: latches the transfer, walks addresses, tracks the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      len_r           <= '0;
      issued_r        <= '0;
      stride_r        <= '0;
      addr_r          <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
    end else begin
      done_r          <= 1'b0;
      inflight_r      <= rd_en_s;
      inflight_last_r <= rd_en_s & last_issue_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            len_r    <= length;
            stride_r <= stride;
            addr_r   <= base_addr;
            issued_r <= '0;
            if (length != '0) begin
              state_r <= RUN;
              busy_r  <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_en_s) begin
            addr_r   <= addr_r + stride_r;
            issued_r <= issued_r + LEN_WIDTH'(1);
            if (last_issue_s) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // The tagged last word leaving the buffer closes the transfer.
          if (pop_s && head_l_r) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Two-entry output buffer as head/tail registers so the stream outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_v_r <= 1'b0;
      head_d_r <= '0;
      head_l_r <= 1'b0;
      tail_v_r <= 1'b0;
      tail_d_r <= '0;
      tail_l_r <= 1'b0;
    end else if (pop_s) begin
      if (tail_v_r) begin
        head_d_r <= tail_d_r;
        head_l_r <= tail_l_r;
        if (inflight_r) begin
          tail_d_r <= mem_rdata;
          tail_l_r <= inflight_last_r;
        end else begin
          tail_v_r <= 1'b0;
        end
      end else if (inflight_r) begin
        head_d_r <= mem_rdata;
        head_l_r <= inflight_last_r;
      end else begin
        head_v_r <= 1'b0;
      end
    end else if (inflight_r) begin
      if (!head_v_r) begin
        head_v_r <= 1'b1;
        head_d_r <= mem_rdata;
        head_l_r <= inflight_last_r;
      end else begin
        tail_v_r <= 1'b1;
        tail_d_r <= mem_rdata;
        tail_l_r <= inflight_last_r;
      end
    end
  end

endmodule
